vit_sym_fetch: RTL and testbench

//  Read-side stage between the input symbol FIFO and the branch-metric unit (BMU).

---
 rtl/vit_sym_fetch.sv | 111 +++++++++++
 tb/tb_vit_sym_fetch.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vit_sym_fetch.sv
// Symbol fetch stage between the soft-symbol FIFO and the branch-metric unit.
// Absorbs the FIFO's registered read latency in a 2-entry buffer and tags each pair with its frame position.
module vit_sym_fetch #(
    parameter int WIDTH     = 16,
    parameter int FRAME_LEN = 64,
    parameter int TAIL_LEN  = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    input  logic [WIDTH-1:0]             fifo_dout,
    output logic                         sym_valid,
    input  logic                         sym_ready,
    output logic [WIDTH/2-1:0]           sym_r0,
    output logic [WIDTH/2-1:0]           sym_r1,
    output logic [$clog2(FRAME_LEN)-1:0] sym_idx,
    output logic                         sym_first,
    output logic                         sym_last,
    output logic                         sym_tail,
    output logic                         frame_done
);

    localparam int SYM_W = WIDTH / 2;
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] TAIL_IDX = IDX_W'(FRAME_LEN - TAIL_LEN);

    logic [1:0]       occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             frame_done_q, frame_done_d;

    logic             xfer;
    logic [1:0]       occ_after;
    logic [2:0]       demand;

    assign sym_valid  = (occ_q != 2'd0);
    assign sym_r0     = slot0_q[SYM_W-1:0];
    assign sym_r1     = slot0_q[WIDTH-1:SYM_W];
    assign sym_idx    = idx_q;
    assign sym_first  = sym_valid && (idx_q == '0);
    assign sym_last   = sym_valid && (idx_q == LAST_IDX);
    assign sym_tail   = sym_valid && (idx_q >= TAIL_IDX);
    assign frame_done = frame_done_q;

    // Slot 0 is always the head; an arriving word lands in the first slot left free after this cycle's read.
    always_comb begin
        xfer         = sym_valid && sym_ready;
        occ_after    = occ_q - {1'b0, xfer};
        demand       = {1'b0, occ_after} + {2'b00, inflight_q};
        fifo_rd_en   = en && !flush && !fifo_empty && (demand < 3'd2);

        occ_d        = occ_q;
        inflight_d   = fifo_rd_en;
        slot0_d      = slot0_q;
        slot1_d      = slot1_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;

        if (flush) begin
            occ_d        = 2'd0;
            idx_d        = '0;
        end else begin
            frame_done_d = xfer && (idx_q == LAST_IDX);
            if (xfer) begin
                slot0_d = slot1_q;
                idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end
            if (inflight_q) begin
                if (occ_after == 2'd0) begin
                    slot0_d = fifo_dout;
                end else begin
                    slot1_d = fifo_dout;
                end
                occ_d = occ_after + 2'd1;
            end else begin
                occ_d = occ_after;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            slot0_q      <= '0;
            slot1_q      <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            occ_q        <= occ_d;
            inflight_q   <= inflight_d;
            slot0_q      <= slot0_d;
            slot1_q      <= slot1_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    occ_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2);

    no_pop_empty_a: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_empty |-> !fifo_rd_en);

endmodule

// File: tb/tb_vit_sym_fetch.sv
// Bench for vit_sym_fetch: behavioural FIFO with registered dout, scoreboard of popped words,
// reference frame counter, and a per-cycle table for the startup sequence.
module tb_vit_sym_fetch;

    localparam int WIDTH     = 16;
    localparam int FRAME_LEN = 64;
    localparam int TAIL_LEN  = 6;
    localparam int IDX_W     = $clog2(FRAME_LEN);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             flush;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_dout;
    logic             sym_valid;
    logic             sym_ready;
    logic [7:0]       sym_r0;
    logic [7:0]       sym_r1;
    logic [IDX_W-1:0] sym_idx;
    logic             sym_first;
    logic             sym_last;
    logic             sym_tail;
    logic             frame_done;

    vit_sym_fetch #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .TAIL_LEN(TAIL_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_r0(sym_r0), .sym_r1(sym_r1),
        .sym_idx(sym_idx), .sym_first(sym_first), .sym_last(sym_last), .sym_tail(sym_tail),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       en;
        bit       ready;
        bit       rd_en;
        bit       valid;
        bit [7:0] r0;
        bit [7:0] r1;
        bit       first;
        int       idx;
    } vec_t;

    vec_t             tbl[6];
    logic [WIDTH-1:0] fifo_mem[$];
    logic [WIDTH-1:0] exp_q[$];
    int               n_vec = 0;
    int               n_err = 0;
    int               exp_idx = 0;
    bit               exp_fd = 0;
    bit               inflight_m = 0;
    bit               pop_pending = 0;
    bit               flush_s = 0;
    int               xfer_cnt = 0, pop_cnt = 0, fd_cnt = 0;
    int               first_cnt = 0, last_cnt = 0, tail_cnt = 0;
    int               base_x, base_p, base_fd, base_f, base_l, base_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input bit e, input bit r, input bit f);
        en        = e;
        sym_ready = r;
        flush     = f;
    endtask

    task automatic pushWord(input logic [WIDTH-1:0] w);
        fifo_mem.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Called at the falling edge: compare against the reference and advance it for the coming edge.
    task automatic sampleCycle();
        bit xf;
        if (!rst_n) begin
            pop_pending = 0;
            flush_s     = 0;
            return;
        end
        checkOutput("rd_while_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
        checkOutput("occupancy", 32'(exp_q.size() <= 2), 32'd1);
        checkOutput("sym_valid", 32'(sym_valid), 32'(exp_q.size() > int'(inflight_m)));
        checkOutput("frame_done", 32'(frame_done), 32'(exp_fd));
        if (sym_valid && exp_q.size() > 0) begin
            checkOutput("pair_data", 32'({sym_r1, sym_r0}), 32'(exp_q[0]));
            checkOutput("sym_idx", 32'(sym_idx), 32'(exp_idx));
            checkOutput("tags", 32'({sym_first, sym_last, sym_tail}),
                        32'({exp_idx == 0, exp_idx == FRAME_LEN - 1, exp_idx >= FRAME_LEN - TAIL_LEN}));
        end
        xf = sym_valid && sym_ready;
        if (xf) begin
            xfer_cnt++;
            if (sym_first) first_cnt++;
            if (sym_last)  last_cnt++;
            if (sym_tail)  tail_cnt++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (frame_done) fd_cnt++;
        exp_fd = xf && !flush && (exp_idx == FRAME_LEN - 1);
        if (flush) exp_idx = 0;
        else if (xf) exp_idx = (exp_idx == FRAME_LEN - 1) ? 0 : exp_idx + 1;
        pop_pending = fifo_rd_en;
        flush_s     = flush;
    endtask

    // FIFO behaviour after the rising edge: a popped word shows on dout for one cycle.
    task automatic modelUpdate();
        logic [WIDTH-1:0] w;
        if (flush_s) begin
            exp_q.delete();
            inflight_m = 0;
        end
        if (pop_pending && fifo_mem.size() > 0) begin
            w = fifo_mem.pop_front();
            fifo_dout = w;
            exp_q.push_back(w);
            pop_cnt++;
        end else begin
            fifo_dout = WIDTH'($urandom);
        end
        inflight_m = pop_pending;
        fifo_empty = (fifo_mem.size() == 0);
    endtask

    task automatic tick();
        @(negedge clk);
        sampleCycle();
        @(posedge clk);
        #1;
        modelUpdate();
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("[TB] FAIL watchdog: got timeout, wanted completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0);
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        #1;
        checkOutput("reset_valid", 32'(sym_valid), 32'd0);
        checkOutput("reset_rd_en", 32'(fifo_rd_en), 32'd0);
        checkOutput("reset_data", 32'({sym_r1, sym_r0}), 32'd0);
        checkOutput("reset_idx", 32'(sym_idx), 32'd0);
        checkOutput("reset_tags", 32'({sym_first, sym_last, sym_tail, frame_done}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] startup latency and ordering");
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 1'b1, 0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 8'h04, 1'b0, 1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h05, 8'h06, 1'b0, 2};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3};
        pushWord(16'h0201);
        pushWord(16'h0403);
        pushWord(16'h0605);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i].en, tbl[i].ready, 1'b0);
            #2;
            checkOutput("t1_rd_en", 32'(fifo_rd_en), 32'(tbl[i].rd_en));
            checkOutput("t1_valid", 32'(sym_valid), 32'(tbl[i].valid));
            checkOutput("t1_idx", 32'(sym_idx), 32'(tbl[i].idx));
            if (tbl[i].valid) begin
                checkOutput("t1_r0", 32'(sym_r0), 32'(tbl[i].r0));
                checkOutput("t1_r1", 32'(sym_r1), 32'(tbl[i].r1));
                checkOutput("t1_first", 32'(sym_first), 32'(tbl[i].first));
            end
            tick();
        end

        $display("[TB] backpressure with a full buffer");
        applyStimulus(1, 0, 0);
        base_p = pop_cnt;
        base_x = xfer_cnt;
        for (int i = 0; i < 4; i++) pushWord(WIDTH'(16'hA000 + i));
        repeat (6) tick();
        #1;
        checkOutput("t2_pops", 32'(pop_cnt - base_p), 32'd2);
        checkOutput("t2_rd_held", 32'(fifo_rd_en), 32'd0);
        checkOutput("t2_head", 32'({sym_r1, sym_r0}), 32'h0000A000);
        applyStimulus(1, 1, 0);
        repeat (8) tick();
        checkOutput("t2_xfers", 32'(xfer_cnt - base_x), 32'd4);
        checkOutput("t2_drained", 32'(exp_q.size() + fifo_mem.size()), 32'd0);

        $display("[TB] full frame with wrap");
        applyStimulus(1, 1, 1);
        tick();
        applyStimulus(1, 1, 0);
        base_x = xfer_cnt; base_fd = fd_cnt; base_f = first_cnt; base_l = last_cnt; base_t = tail_cnt;
        for (int i = 0; i < FRAME_LEN + 2; i++) pushWord(WIDTH'($urandom));
        repeat (FRAME_LEN + 8) tick();
        checkOutput("t3_xfers", 32'(xfer_cnt - base_x), 32'(FRAME_LEN + 2));
        checkOutput("t3_frame_done", 32'(fd_cnt - base_fd), 32'd1);
        checkOutput("t3_first", 32'(first_cnt - base_f), 32'd2);
        checkOutput("t3_last", 32'(last_cnt - base_l), 32'd1);
        checkOutput("t3_tail", 32'(tail_cnt - base_t), 32'(TAIL_LEN));

        $display("[TB] flush with a word in flight");
        applyStimulus(1, 0, 0);
        pushWord(16'h1111);
        tick();
        tick();
        pushWord(16'h2222);
        #1;
        checkOutput("t4_occ1_valid", 32'(sym_valid), 32'd1);
        checkOutput("t4_pop", 32'(fifo_rd_en), 32'd1);
        tick();
        pushWord(16'h3333);
        applyStimulus(1, 0, 1);
        #1;
        checkOutput("t4_no_pop_flush", 32'(fifo_rd_en), 32'd0);
        tick();
        applyStimulus(1, 0, 0);
        #1;
        checkOutput("t4_valid_cleared", 32'(sym_valid), 32'd0);
        checkOutput("t4_idx_cleared", 32'(sym_idx), 32'd0);
        checkOutput("t4_repop", 32'(fifo_rd_en), 32'd1);
        base_x = xfer_cnt;
        base_f = first_cnt;
        tick();
        applyStimulus(1, 1, 0);
        repeat (5) tick();
        checkOutput("t4_xfers", 32'(xfer_cnt - base_x), 32'd1);
        checkOutput("t4_first", 32'(first_cnt - base_f), 32'd1);

        $display("[TB] random traffic");
        for (int c = 0; c < 10000; c++) begin
            if (fifo_mem.size() < 3 && $urandom_range(0, 2) != 0) pushWord(WIDTH'($urandom));
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, 1'b0);
            tick();
        end
        applyStimulus(0, 1, 0);
        repeat (4) tick();
        checkOutput("t5_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] asynchronous reset mid-frame");
        applyStimulus(1, 1, 0);
        for (int i = 0; i < 5; i++) pushWord(WIDTH'(16'hC000 + i));
        repeat (4) tick();
        applyStimulus(1, 0, 0);
        repeat (4) tick();
        #1;
        checkOutput("t6_pre_valid", 32'(sym_valid), 32'd1);
        rst_n = 1'b0;
        fifo_mem.delete();
        fifo_empty = 1'b1;
        exp_q.delete();
        exp_idx    = 0;
        exp_fd     = 0;
        inflight_m = 0;
        #1;
        checkOutput("t6_valid", 32'(sym_valid), 32'd0);
        checkOutput("t6_rd_en", 32'(fifo_rd_en), 32'd0);
        checkOutput("t6_data", 32'({sym_r1, sym_r0}), 32'd0);
        checkOutput("t6_idx", 32'(sym_idx), 32'd0);
        checkOutput("t6_tags", 32'({sym_first, sym_last, sym_tail, frame_done}), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        applyStimulus(1, 1, 0);
        base_x = xfer_cnt;
        base_f = first_cnt;
        pushWord(16'h5A5A);
        repeat (5) tick();
        checkOutput("t6_xfers", 32'(xfer_cnt - base_x), 32'd1);
        checkOutput("t6_first", 32'(first_cnt - base_f), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
